dmem_responder: RTL and testbench
=================================

// Module: dmem_responder
// PURPOSE
//  Data-memory responder (target side) of the CPU load/store bus; the core's LSU is the initiator.
//  - Accepts one request at a time over a valid/ready handshake.
//  - Inserts a programmable number of wait states.
//  - Performs a byte-enabled read or write to local storage.
//  - Returns the result over a separate valid/ready response channel.
//  - Sits between the CPU core and the on-chip data RAM.
// PARAMETERS
//  ADDR_W       8   word-address width
//  DATA_W       32  data width; must be a multiple of 8
//  DEPTH        256 number of storage words; DEPTH <= 2**ADDR_W
//  WAIT_CYCLES  2   wait states between accept and response (0..15)
// PORTS
//  clk        in   1         rising-edge clock
//  rst_n      in   1         asynchronous, active-low reset
//  req_valid  in   1         request present
//  req_ready  out  1         responder can accept a request
//  req_we     in   1         1 = write, 0 = read
//  req_addr   in   ADDR_W    word address
//  req_wdata  in   DATA_W    write data
//  req_be     in   DATA_W/8  byte enables (write only; reads return the full word)
//  rsp_valid  out  1         response present
//  rsp_ready  in   1         initiator takes the response
//  rsp_rdata  out  DATA_W    read data; 0 for write responses
//  rsp_err    out  1         error flag; see CONFIGURATION
// BEHAVIOUR
//  Reset values (async, rst_n=0): req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, state=IDLE.
//  - Storage contents are not reset.
//  req_ready is registered:
//  - It goes to 1 on the first clk edge after rst_n deasserts.
//  - It is 1 only in IDLE.
//  States and transitions:
//  - IDLE: when req_valid && req_ready at edge T:
//    - latch we/addr/wdata/be;
//    - load wait counter with WAIT_CYCLES;
//    - go to WAIT; req_ready goes to 0.
//  - WAIT: if the counter is 0, go to RESP; otherwise decrement the counter.
//  - On the WAIT->RESP edge, the access commits:
//    - write: bytes with be[i]=1 are updated; rsp_rdata=0;
//    - read: rsp_rdata = mem[addr].
//  - RESP: rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1.
//  - On the RESP edge with rsp_ready=1: go to IDLE; rsp_valid goes to 0, req_ready goes to 1.
//  Timing:
//  - Latency: rsp_valid is first high after edge T+WAIT_CYCLES+1.
//  - Minimum request spacing: WAIT_CYCLES+3 cycles.
//  Boundary conditions:
//  - req_be=0 on a write is a legal no-op write that still responds.
//  - req_valid while req_ready=0 is ignored; the initiator holds the request.
//  - rsp_ready held low: stay in RESP indefinitely; no new request is accepted.
//  - Address wrap (macro off): the index is req_addr mod DEPTH.
//  - Reset mid-transaction: return to IDLE immediately; the in-flight transaction is dropped.
//    - A write not yet committed is lost; committed data is retained.
// CONFIGURATION
//  DMEM_BOUNDS_EN defined:
//  - req_addr >= DEPTH responds with rsp_err=1 and rsp_rdata=0.
//  - A write to such an address is suppressed.
//  - Timing is unchanged.
//  DMEM_BOUNDS_EN undefined:
//  - Addresses wrap modulo DEPTH; rsp_err is tied to 0.
// STRUCTURE
//  Shared package cpu_bus_pkg holds:
//  - state encodings IDLE=2'd0, WAIT=2'd1, RESP=2'd2;
//  - bus width localparams (ADDR_W, DATA_W) shared with the LSU.
//  Sub-module dmem_array (byte-enabled single-port storage):
//  - ports: clk, we, be, addr, wdata, rdata.
//  - This module owns the FSM, wait counter, request latches, and bounds check.
// TESTING (DATA_W=32, DEPTH=256, WAIT_CYCLES=2 unless noted)
//  1. Write addr 0x10 data 0xDEADBEEF, be=4'hF; then read 0x10.
//     -> rsp_rdata=0xDEADBEEF; rsp_valid exactly 3 cycles after each accept.
//  2. Write 0x10 data 0x11223344, be=4'b0101; then read 0x10.
//     -> rsp_rdata=0xDE22BE44.
//  3. Hold rsp_ready=0 for 5 cycles in RESP, with req_valid=1.
//     -> rsp_valid and rsp_rdata stable; req_ready stays 0; no second accept.
//  4. Drop rst_n for 1 cycle in WAIT during a write of 0xCAFEF00D to 0x20.
//     -> outputs return to reset values; a following read of 0x20 returns its prior contents.
//  5. WAIT_CYCLES=0, back-to-back reads with rsp_ready=1.
//     -> rsp_valid 1 cycle after accept; accepts every 3 cycles.
//  6. Macro on, DEPTH=128, write 0xFFFFFFFF to 0x80.
//     -> rsp_err=1; read 0x00 unchanged.
//     Macro off, same stimulus -> rsp_err=0; read 0x00 = 0xFFFFFFFF.

Source files
------------

// File: rtl/cpu_bus_pkg.sv
// Shared CPU load/store bus definitions: bus widths and the data-memory responder state encoding.
package cpu_bus_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/dmem_array.sv
// Byte-enabled single-port word storage with combinational read; the responder registers the read data.
module dmem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [AW-1:0]         addr,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  // NOTE: storage has no reset; clearing every word would need a reset fan-out to each bit and
  // contents are defined only once written.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (be[i]) mem_q[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder on the CPU load/store bus: valid/ready request, programmable wait states,
// byte-enabled access, valid/ready response. Define DMEM_BOUNDS_EN to flag out-of-range addresses.
module dmem_responder #(
  parameter int ADDR_W      = cpu_bus_pkg::ADDR_W,
  parameter int DATA_W      = cpu_bus_pkg::DATA_W,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_be,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  import cpu_bus_pkg::*;

  localparam int         BE_W      = DATA_W / 8;
  localparam int         IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_e              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [BE_W-1:0]     be_q;

  logic                accept;
  logic                commit;
  logic                oob;
  logic                mem_we;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   mem_rdata;

  assign accept = req_valid && req_ready_q;
  assign commit = (state_q == WAIT) && (cnt_q == '0);
  assign idx    = IDX_W'(32'(addr_q) % 32'(DEPTH));
  assign mem_we = commit && we_q && !oob;

`ifdef DMEM_BOUNDS_EN
  logic rsp_err_q;

  assign oob = 32'(addr_q) >= 32'(DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rsp_err_q <= 1'b0;
    else if (commit) rsp_err_q <= oob;
  end

  assign rsp_err = rsp_err_q;
`else
  assign oob     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .be    (be_q),
    .addr  (idx),
    .wdata (wdata_q),
    .rdata (mem_rdata)
  );

  // NOTE: every signal driven here gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rsp_rdata_d = rsp_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = WAIT;
          cnt_d   = WAIT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_rdata_d = (we_q || oob) ? '0 : mem_rdata;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Both handshake outputs are registered views of the next state.
    req_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        be_q    <= req_be;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (WAIT=2/DEPTH=256, WAIT=0, DEPTH=128).
module tb_dmem_responder;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;

  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_we    [3];
  logic [7:0]  req_addr  [3];
  logic [31:0] req_wdata [3];
  logic [3:0]  req_be    [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .rsp_err(rsp_err[0])
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .rsp_err(rsp_err[1])
  );

  dmem_responder #(.ADDR_W(8), .DATA_W(32), .DEPTH(128), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid[2]), .req_ready(req_ready[2]), .req_we(req_we[2]),
    .req_addr(req_addr[2]), .req_wdata(req_wdata[2]), .req_be(req_be[2]),
    .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
    .rsp_err(rsp_err[2])
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One full transaction; lat counts clock edges from the accept edge to the first rsp_valid.
  task automatic txn(input int k, input logic we, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, output logic [31:0] rdata, output logic err,
                     output int lat);
    int n;
    rdata = '0;
    err   = 1'b0;
    lat   = -1;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    req_be[k]    = be;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      total++;
      $display("FAIL accept_timeout dut%0d: req_ready stayed %b, wanted 1", k, req_ready[k]);
      req_valid[k] = 1'b0;
      return;
    end
    @(negedge clk);
    req_valid[k] = 1'b0;
    lat = 0;
    while (rsp_valid[k] !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 100) begin
      total++;
      $display("FAIL response_timeout dut%0d: rsp_valid stayed %b, wanted 1", k, rsp_valid[k]);
      return;
    end
    rdata = rsp_rdata[k];
    err   = rsp_err[k];
    rsp_ready[k] = 1'b1;
    @(negedge clk);
    rsp_ready[k] = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    total++; if (req_ready[0] === 1'b0) passed++;
    else $display("FAIL reset_req_ready: got %b want 0", req_ready[0]);
    total++; if (rsp_valid[0] === 1'b0) passed++;
    else $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid[0]);
    total++; if (rsp_rdata[0] === 32'h0) passed++;
    else $display("FAIL reset_rsp_rdata: got %h want 0", rsp_rdata[0]);
    total++; if (rsp_err[0] === 1'b0) passed++;
    else $display("FAIL reset_rsp_err: got %b want 0", rsp_err[0]);
    rst_n = 1'b1;
    #1;
    total++; if (req_ready[0] === 1'b0) passed++;
    else $display("FAIL ready_before_edge: got %b want 0", req_ready[0]);
    @(negedge clk);
    total++; if (req_ready[0] === 1'b1) passed++;
    else $display("FAIL ready_after_edge: got %b want 1", req_ready[0]);
  endtask

  task automatic test_write_read();
    logic [31:0] d; logic e; int lat;
    txn(0, 1'b1, 8'h10, 32'hDEADBEEF, 4'hF, d, e, lat);
    total++; if (lat == 3) passed++;
    else $display("FAIL write_latency: got %0d want 3", lat);
    total++; if (d === 32'h0) passed++;
    else $display("FAIL write_rsp_rdata: got %h want 00000000", d);
    total++; if (e === 1'b0) passed++;
    else $display("FAIL write_rsp_err: got %b want 0", e);
    txn(0, 1'b0, 8'h10, 32'h0, 4'h0, d, e, lat);
    total++; if (lat == 3) passed++;
    else $display("FAIL read_latency: got %0d want 3", lat);
    total++; if (d === 32'hDEADBEEF) passed++;
    else $display("FAIL read_full_word: got %h want deadbeef", d);
  endtask

  task automatic test_byte_enable();
    logic [31:0] d; logic e; int lat;
    txn(0, 1'b1, 8'h10, 32'h11223344, 4'b0101, d, e, lat);
    txn(0, 1'b0, 8'h10, 32'h0, 4'h0, d, e, lat);
    total++; if (d === 32'hDE22BE44) passed++;
    else $display("FAIL byte_enable_merge: got %h want de22be44", d);
    // All-zero byte enables: legal no-op write that still responds.
    txn(0, 1'b1, 8'h10, 32'hFFFFFFFF, 4'h0, d, e, lat);
    total++; if (lat == 3) passed++;
    else $display("FAIL noop_write_latency: got %0d want 3", lat);
    txn(0, 1'b0, 8'h10, 32'h0, 4'h0, d, e, lat);
    total++; if (d === 32'hDE22BE44) passed++;
    else $display("FAIL noop_write_kept: got %h want de22be44", d);
  endtask

  task automatic test_rsp_stall();
    int n;
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 8'h10;
    req_wdata[0] = 32'h0; req_be[0] = 4'h0;
    @(negedge clk);
    // A second request stays presented for the whole stall.
    req_we[0] = 1'b1; req_addr[0] = 8'h30; req_wdata[0] = 32'h55555555; req_be[0] = 4'hF;
    n = 0;
    while (rsp_valid[0] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    repeat (5) begin
      total++; if (rsp_valid[0] === 1'b1) passed++;
      else $display("FAIL stall_rsp_valid: got %b want 1", rsp_valid[0]);
      total++; if (rsp_rdata[0] === 32'hDE22BE44) passed++;
      else $display("FAIL stall_rsp_rdata: got %h want de22be44", rsp_rdata[0]);
      total++; if (req_ready[0] === 1'b0) passed++;
      else $display("FAIL stall_req_ready: got %b want 0", req_ready[0]);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    rsp_ready[0] = 1'b0;
    total++; if (req_ready[0] === 1'b1 && rsp_valid[0] === 1'b0) passed++;
    else $display("FAIL stall_release: got ready=%b valid=%b want ready=1 valid=0",
                  req_ready[0], rsp_valid[0]);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int lat;
    txn(0, 1'b1, 8'h20, 32'h01234567, 4'hF, d, e, lat);
    txn(0, 1'b0, 8'h20, 32'h0, 4'h0, d, e, lat);
    req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 8'h20;
    req_wdata[0] = 32'hCAFEF00D; req_be[0] = 4'hF;
    @(negedge clk);
    req_valid[0] = 1'b0;
    rst_n = 1'b0;
    #1;
    total++; if (req_ready[0] === 1'b0 && rsp_valid[0] === 1'b0) passed++;
    else $display("FAIL midreset_handshake: got ready=%b valid=%b want 0/0",
                  req_ready[0], rsp_valid[0]);
    total++; if (rsp_rdata[0] === 32'h0 && rsp_err[0] === 1'b0) passed++;
    else $display("FAIL midreset_data: got rdata=%h err=%b want 0/0", rsp_rdata[0], rsp_err[0]);
    @(negedge clk);
    rst_n = 1'b1;
    txn(0, 1'b0, 8'h20, 32'h0, 4'h0, d, e, lat);
    total++; if (d === 32'h01234567) passed++;
    else $display("FAIL midreset_write_dropped: got %h want 01234567", d);
    total++; if (lat == 3) passed++;
    else $display("FAIL midreset_latency: got %0d want 3", lat);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d; logic e; int lat;
    int acc_n, rsp_n, last;
    for (int i = 0; i < 4; i++) begin
      txn(1, 1'b1, 8'(5 + i), 32'hA5A50005 + 32'(i), 4'hF, d, e, lat);
    end
    total++; if (lat == 1) passed++;
    else $display("FAIL w0_latency: got %0d want 1", lat);
    acc_n = 0; rsp_n = 0; last = -10;
    rsp_ready[1] = 1'b1;
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_wdata[1] = 32'h0; req_be[1] = 4'h0;
    for (int cyc = 0; cyc < 12; cyc++) begin
      // Sampled at negedges: an accept seen at cyc responds at cyc+2 (one edge after accept).
      if (rsp_valid[1] === 1'b1) begin
        total++; if (rsp_rdata[1] === 32'hA5A50005 + 32'(rsp_n) && cyc == last + 2) passed++;
        else $display("FAIL b2b_response%0d: got %h at %0d want %h at %0d", rsp_n, rsp_rdata[1],
                      cyc, 32'hA5A50005 + 32'(rsp_n), last + 2);
        rsp_n++;
      end
      if (req_ready[1] === 1'b1) begin
        if (acc_n > 0) begin
          total++; if (cyc - last == 3) passed++;
          else $display("FAIL b2b_spacing: got %0d want 3", cyc - last);
        end
        req_addr[1] = 8'(5 + acc_n);
        last = cyc;
        acc_n++;
      end
      @(negedge clk);
    end
    req_valid[1] = 1'b0;
    rsp_ready[1] = 1'b0;
    total++; if (acc_n == 4 && rsp_n == 4) passed++;
    else $display("FAIL b2b_counts: got acc=%0d rsp=%0d want 4/4", acc_n, rsp_n);
  endtask

  task automatic test_bounds();
    logic [31:0] d; logic e; int lat;
    logic        exp_err;
    logic [31:0] exp_word0;
`ifdef DMEM_BOUNDS_EN
    exp_err   = 1'b1;
    exp_word0 = 32'h0;
`else
    exp_err   = 1'b0;
    exp_word0 = 32'hFFFFFFFF;
`endif
    txn(2, 1'b1, 8'h00, 32'h0, 4'hF, d, e, lat);
    txn(2, 1'b1, 8'h80, 32'hFFFFFFFF, 4'hF, d, e, lat);
    total++; if (e === exp_err) passed++;
    else $display("FAIL bounds_write_err: got %b want %b", e, exp_err);
    total++; if (d === 32'h0 && lat == 3) passed++;
    else $display("FAIL bounds_write_rsp: got rdata=%h lat=%0d want 0/3", d, lat);
    txn(2, 1'b0, 8'h00, 32'h0, 4'h0, d, e, lat);
    total++; if (d === exp_word0) passed++;
    else $display("FAIL bounds_word0: got %h want %h", d, exp_word0);
    total++; if (e === 1'b0) passed++;
    else $display("FAIL bounds_inrange_err: got %b want 0", e);
`ifdef DMEM_BOUNDS_EN
    txn(2, 1'b0, 8'h80, 32'h0, 4'h0, d, e, lat);
    total++; if (e === 1'b1 && d === 32'h0) passed++;
    else $display("FAIL bounds_read_oob: got err=%b rdata=%h want 1/0", e, d);
`endif
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0; req_we[k] = 1'b0; req_addr[k] = '0;
      req_wdata[k] = '0;   req_be[k] = '0;   rsp_ready[k] = 1'b0;
    end
    test_reset();
    test_write_read();
    test_byte_enable();
    test_rsp_stall();
    test_reset_mid();
    test_back_to_back();
    test_bounds();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
